// File: rtl/evaluate_taper_sum_pkg.sv
// Shared constants, state encoding and width helpers for the taper-sum evaluator.
package evaluate_taper_sum_pkg;

    localparam int unsigned DEF_EVAL_WIDTH  = 24;
    localparam int unsigned DEF_NUM_TERMS   = 4;
    localparam int unsigned DEF_PHASE_SHIFT = 8;
    localparam int unsigned DEF_TIMEOUT     = 64;
    localparam int unsigned DEF_FULL_PHASE  = 32'd1 << DEF_PHASE_SHIFT;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SUM   = 3'd2,
        ST_TAPER = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    // Width that holds the sum of nt signed ew-bit terms without overflow.
    function automatic int unsigned sum_width(input int unsigned ew, input int unsigned nt);
        return ew + $clog2(nt);
    endfunction

endpackage

// File: rtl/evaluate_taper_sum_if.sv
// Evaluator-bank side bus of the taper-sum block: board control, terms in, tapered score out.
interface evaluate_taper_sum_if
    import evaluate_taper_sum_pkg::*;
#(
    parameter int unsigned EVAL_WIDTH  = DEF_EVAL_WIDTH,
    parameter int unsigned NUM_TERMS   = DEF_NUM_TERMS,
    parameter int unsigned PHASE_SHIFT = DEF_PHASE_SHIFT
);
    logic                            board_valid;
    logic                            clear_eval;
    logic [PHASE_SHIFT:0]            phase;
    logic [NUM_TERMS-1:0]            term_valid;
    logic [NUM_TERMS*EVAL_WIDTH-1:0] term_mg;
    logic [NUM_TERMS*EVAL_WIDTH-1:0] term_eg;
    logic [EVAL_WIDTH-1:0]           eval;
    logic                            eval_valid;
    logic                            eval_error;

    modport master (
        output board_valid, clear_eval, phase, term_valid, term_mg, term_eg,
        input  eval, eval_valid, eval_error
    );

    modport slave (
        input  board_valid, clear_eval, phase, term_valid, term_mg, term_eg,
        output eval, eval_valid, eval_error
    );
endinterface

// File: rtl/evaluate_taper_sum_taper_mac.sv
// Registered phase blend: (mg*ph + eg*(full-ph)) >>> PHASE_SHIFT, saturated to the symmetric score range.
module evaluate_taper_sum_taper_mac #(
    parameter int unsigned EVAL_WIDTH  = 24,
    parameter int unsigned SUM_W       = 26,
    parameter int unsigned PHASE_SHIFT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_i,
    input  logic signed [SUM_W-1:0]      sum_mg_i,
    input  logic signed [SUM_W-1:0]      sum_eg_i,
    input  logic        [PHASE_SHIFT:0]  phase_i,
    output logic signed [EVAL_WIDTH-1:0] eval_o
);
    localparam int unsigned PW         = SUM_W + PHASE_SHIFT + 3;
    localparam int unsigned FULL_PHASE = 32'd1 << PHASE_SHIFT;
    localparam logic signed [PW-1:0] MAX_S = PW'({(EVAL_WIDTH-1){1'b1}});
    localparam logic signed [PW-1:0] MIN_S = -MAX_S;

    logic signed [PHASE_SHIFT+1:0] ph_c;
    logic signed [PHASE_SHIFT+1:0] inv_c;
    logic signed [PW-1:0]          prod_c;
    logic signed [PW-1:0]          shr_c;
    logic signed [PW-1:0]          sat_c;
    logic signed [EVAL_WIDTH-1:0]  eval_q;

    // Arithmetic shift gives floor rounding; clamp is symmetric, so -2**(W-1) is never produced.
    always_comb begin
        ph_c   = $signed({1'b0, phase_i});
        inv_c  = $signed((PHASE_SHIFT+2)'(FULL_PHASE)) - ph_c;
        prod_c = PW'(sum_mg_i) * PW'(ph_c) + PW'(sum_eg_i) * PW'(inv_c);
        shr_c  = prod_c >>> PHASE_SHIFT;
        if (shr_c > MAX_S) begin
            sat_c = MAX_S;
        end else if (shr_c < MIN_S) begin
            sat_c = MIN_S;
        end else begin
            sat_c = shr_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eval_q <= '0;
        end else if (load_i) begin
            eval_q <= EVAL_WIDTH'(sat_c);
        end
    end

    assign eval_o = eval_q;

endmodule

// File: rtl/evaluate_taper_sum.sv
// Collects per-evaluator mg/eg terms, sums them and blends by game phase into one signed score.
module evaluate_taper_sum
    import evaluate_taper_sum_pkg::*;
#(
    parameter int unsigned EVAL_WIDTH  = DEF_EVAL_WIDTH,
    parameter int unsigned NUM_TERMS   = DEF_NUM_TERMS,
    parameter int unsigned PHASE_SHIFT = DEF_PHASE_SHIFT,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input logic                 clk,
    input logic                 reset,
    evaluate_taper_sum_if.slave bus
);
    localparam int unsigned SUM_W      = sum_width(EVAL_WIDTH, NUM_TERMS);
    localparam int unsigned PH_W       = PHASE_SHIFT + 1;
    localparam int unsigned TMR_W      = $clog2(TIMEOUT) + 1;
    localparam int unsigned FULL_PHASE = 32'd1 << PHASE_SHIFT;

    state_e                       state_q, state_d;
    logic [NUM_TERMS-1:0]         flags_q, flags_d;
    logic [NUM_TERMS-1:0]         cap_c;
    logic [TMR_W-1:0]             timer_q, timer_d;
    logic [PH_W-1:0]              phase_q, phase_d, phase_clamp_c;
    logic signed [SUM_W-1:0]      sum_mg_q, sum_mg_d, sum_mg_c;
    logic signed [SUM_W-1:0]      sum_eg_q, sum_eg_d, sum_eg_c;
    logic                         eval_valid_q, eval_valid_d;
    logic                         eval_error_q, eval_error_d;
    logic                         load_c;
    logic signed [EVAL_WIDTH-1:0] mg_q [NUM_TERMS];
    logic signed [EVAL_WIDTH-1:0] eg_q [NUM_TERMS];
    logic signed [EVAL_WIDTH-1:0] eval_q;

    assign phase_clamp_c = (bus.phase > PH_W'(FULL_PHASE)) ? PH_W'(FULL_PHASE) : bus.phase;

    // Only first arrival of each term is kept; board_valid/clear_eval cycles discard captures.
    assign cap_c = (state_q == ST_WAIT && !bus.board_valid && !bus.clear_eval)
                 ? (bus.term_valid & ~flags_q) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_TERMS); i++) begin
                mg_q[i] <= '0;
                eg_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_TERMS); i++) begin
                if (cap_c[i]) begin
                    mg_q[i] <= $signed(bus.term_mg[i*EVAL_WIDTH +: EVAL_WIDTH]);
                    eg_q[i] <= $signed(bus.term_eg[i*EVAL_WIDTH +: EVAL_WIDTH]);
                end
            end
        end
    end

    always_comb begin
        sum_mg_c = '0;
        sum_eg_c = '0;
        for (int i = 0; i < int'(NUM_TERMS); i++) begin
            sum_mg_c = sum_mg_c + SUM_W'(mg_q[i]);
            sum_eg_c = sum_eg_c + SUM_W'(eg_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            flags_q      <= '0;
            timer_q      <= '0;
            phase_q      <= '0;
            sum_mg_q     <= '0;
            sum_eg_q     <= '0;
            eval_valid_q <= 1'b0;
            eval_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flags_q      <= flags_d;
            timer_q      <= timer_d;
            phase_q      <= phase_d;
            sum_mg_q     <= sum_mg_d;
            sum_eg_q     <= sum_eg_d;
            eval_valid_q <= eval_valid_d;
            eval_error_q <= eval_error_d;
        end
    end

    // board_valid outranks clear_eval, which outranks normal sequencing.
    always_comb begin
        state_d      = state_q;
        flags_d      = flags_q;
        timer_d      = timer_q;
        phase_d      = phase_q;
        sum_mg_d     = sum_mg_q;
        sum_eg_d     = sum_eg_q;
        eval_valid_d = eval_valid_q;
        eval_error_d = eval_error_q;
        load_c       = 1'b0;

        if (bus.board_valid) begin
            phase_d      = phase_clamp_c;
            flags_d      = '0;
            timer_d      = '0;
            eval_valid_d = 1'b0;
            eval_error_d = 1'b0;
            state_d      = ST_WAIT;
        end else if (bus.clear_eval) begin
            flags_d      = '0;
            timer_d      = '0;
            eval_valid_d = 1'b0;
            eval_error_d = 1'b0;
            state_d      = ST_IDLE;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    flags_d = flags_q | cap_c;
                    timer_d = timer_q + TMR_W'(1);
                    if (&flags_d) begin
                        state_d = ST_SUM;
                    end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        eval_error_d = 1'b1;
                        state_d      = ST_ERR;
                    end
                end
                ST_SUM: begin
                    sum_mg_d = sum_mg_c;
                    sum_eg_d = sum_eg_c;
                    state_d  = ST_TAPER;
                end
                ST_TAPER: begin
                    load_c       = 1'b1;
                    eval_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end
                ST_IDLE, ST_DONE, ST_ERR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    evaluate_taper_sum_taper_mac #(
        .EVAL_WIDTH  (EVAL_WIDTH),
        .SUM_W       (SUM_W),
        .PHASE_SHIFT (PHASE_SHIFT)
    ) u_taper_mac (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load_c),
        .sum_mg_i (sum_mg_q),
        .sum_eg_i (sum_eg_q),
        .phase_i  (phase_q),
        .eval_o   (eval_q)
    );

    assign bus.eval       = eval_q;
    assign bus.eval_valid = eval_valid_q;
    assign bus.eval_error = eval_error_q;

endmodule
